u_recv: RTL and testbench
=========================

# u_recv

Serial receive half of the UART: recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) from the incoming line and presents each byte on a parallel bus with a one-cycle strobe. It pairs with the transmitter at the other end of the link. The divider uses the same tick scheme as the transmitter, so both directions share one baud configuration. Start detection uses glitch rejection; data and stop bits are sampled at mid-bit; stop-bit violations are flagged as framing errors.

## Interface
- CLOCK_DIVIDE, 1302: sys_clk cycles per sample tick (50 MHz / (9600 × 4)); legal range 2..65535.
- SAMPLES, 4: ticks per bit period; must be even, legal range 4..16.
- sys_clk  in  1  master clock; all logic on rising edge.
- sys_rst_I  in  1  reset; asynchronous and active-high.
- uart_RECV_dataH  in  1  incoming serial line, idle high, asynchronous to sys_clk.
- recv_dataH  out  8  last correctly framed byte; holds until the next good frame.
- recv_readyH  out  1  one-cycle strobe: recv_dataH was updated this cycle.
- recv_errH  out  1  one-cycle strobe: framing error (stop bit sampled low).
- recv_busyH  out  1  high while a frame is in progress (any state but IDLE).

## Operation
- **Line synchronizer**
  - uart_RECV_dataH passes through a 2-flop synchronizer; both flops reset to 1.
  - The FSM sees only the synchronizer output `rx_s`.
- **Tick generator**
  - 16-bit divider, reloaded to CLOCK_DIVIDE−1 on every entry to START.
  - A tick fires when the divider reads 0; the divider then reloads to CLOCK_DIVIDE−1 and otherwise decrements.
  - The first tick falls exactly CLOCK_DIVIDE cycles after START entry.
  - A 5-bit tick counter counts ticks within the current phase.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: divider frozen. If rx_s = 0, go to START, load the divider and clear the tick counter.
  - START: after SAMPLES/2 ticks (mid start bit), sample rx_s.
    - If 0: go to DATA with bit count 0.
    - If 1: treat as a glitch and return to IDLE with no strobe.
  - DATA: every SAMPLES ticks, sample rx_s into shift register bit [7] and shift right. This lands the first received bit in bit [0].
    - After the 8th sample, go to STOP.
  - STOP: after SAMPLES ticks, sample rx_s.
    - If 1: load recv_dataH from the shift register, pulse recv_readyH, go to IDLE.
    - If 0: pulse recv_errH, leave recv_dataH unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s = 1, then go to IDLE. A break or stuck-low line produces exactly one recv_errH and no further frames.
- Returning to IDLE at mid stop bit is required. A following start edge arriving half a bit later must be caught; there is no minimum inter-frame gap.
- recv_busyH = (state ≠ IDLE), registered with the state.
- Width rules:
  - Bit counter is 4 bits, range 0..8.
  - Tick counter compares against SAMPLES/2 and SAMPLES, reaches at most 16, and never wraps.
  - Divider arithmetic is unsigned.

## Timing
- **Reset values:**
  - recv_dataH = 8'h00; recv_readyH = 0; recv_errH = 0; recv_busyH = 0.
  - state = IDLE; shift register = 0; synchronizer = 2'b11.
- Reset asserted mid-frame aborts immediately: no strobe, recv_dataH = 0. After release, the block waits in IDLE for a fresh falling edge; a line still low at release starts a new frame.
- **Falling edge to START:** with the line falling between edges, START is entered on the 3rd rising edge after the fall (edges 1–2 synchronizer, edge 3 state). recv_busyH rises on that edge.
- **START entry to stop sample (edge E0 = START entry):**
  - The stop sample is taken on edge E0 + (SAMPLES/2 + 9·SAMPLES)·CLOCK_DIVIDE.
  - recv_readyH (or recv_errH) and recv_dataH are valid during the cycle following that edge.
  - recv_busyH falls on the same edge (good frame).
- **Strobes:**
  - recv_readyH and recv_errH are each exactly one cycle wide and never high together.
  - There is no back-pressure; the consumer must capture recv_dataH on recv_readyH.
  - A new good frame overwrites recv_dataH; no overrun flag.
- **Minimum pulses:** a low pulse shorter than SAMPLES/2 ticks is rejected as a glitch. Mid-bit sampling tolerates ±(SAMPLES/2 − 1) ticks of accumulated skew per frame.

## Test plan
Bench parameters: CLOCK_DIVIDE = 4, SAMPLES = 4 (bit = 16 cycles, stop sample 152 cycles after START entry). Bench drives ideal bit periods unless stated.

- **Good frame:** send 0xA5 (line 0,1,0,1,0,0,1,0,1,1) → recv_readyH one cycle, recv_dataH = 8'hA5, recv_errH = 0, recv_busyH high for exactly 152 cycles.
- **Glitch rejection:** drive the line low for 6 cycles, then high → recv_busyH pulses, returns to IDLE after 8 cycles in START, no strobe, recv_dataH unchanged.
- **Framing error:** send 0x3C with the stop bit low, then hold low 40 more cycles → one recv_errH pulse, recv_dataH keeps its prior value, state stays in WAIT_HIGH until the line goes high.
- **Back-to-back frames:** 0x00 then 0xFF with a single stop bit and no gap → two recv_readyH pulses exactly 160 cycles apart, values 8'h00 then 8'hFF.
- **Reset mid-frame:** assert sys_rst_I asynchronously in the 4th data bit of 0x81 → all outputs reset immediately. A subsequent 0x7E is received correctly.
- **Loopback with the transmitter:** both blocks at default parameters, transmit 0x55 → recv_dataH = 8'h55 with recv_readyH, no recv_errH.

Source files
------------

// File: rtl/u_recv.sv
// 8N1 UART receiver: synchronizes the serial line, detects a start bit with glitch
// rejection, samples data and stop bits at mid-bit, and strobes each byte or framing error.
module u_recv #(
  parameter int unsigned CLOCK_DIVIDE = 1302,
  parameter int unsigned SAMPLES      = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_I,
  input  logic       uart_RECV_dataH,
  output logic [7:0] recv_dataH,
  output logic       recv_readyH,
  output logic       recv_errH,
  output logic       recv_busyH
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  localparam logic [15:0] DIV_RELOAD = 16'(CLOCK_DIVIDE - 1);
  localparam logic [4:0]  HALF_LAST  = 5'(SAMPLES / 2 - 1);
  localparam logic [4:0]  FULL_LAST  = 5'(SAMPLES - 1);

  state_t      state;
  state_t      state_next;
  logic [1:0]  sync;
  logic        rx_s;
  logic [15:0] div;
  logic [4:0]  tick_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift;

  logic        running;
  logic        tick;
  logic        half_done;
  logic        full_done;
  logic        start_load;
  logic        phase_end;
  logic        sample_bit;
  logic        frame_good;
  logic        frame_bad;

  assign rx_s = sync[1];

  // The divider and tick counter only advance while a bit phase is being timed;
  // WAIT_HIGH just watches the line, so the tick counter can never wrap.
  assign running   = (state == START) || (state == DATA) || (state == STOP);
  assign tick      = running && (div == 16'd0);
  assign half_done = tick && (tick_cnt == HALF_LAST);
  assign full_done = tick && (tick_cnt == FULL_LAST);

  // State register; busy is registered alongside so it tracks state exactly.
  always_ff @(posedge sys_clk or posedge sys_rst_I) begin
    if (sys_rst_I) begin
      state      <= IDLE;
      recv_busyH <= 1'b0;
    end else begin
      state      <= state_next;
      recv_busyH <= (state_next != IDLE);
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: a default on every path keeps this block purely combinational (no latch).
    state_next = state;
    unique case (state)
      IDLE:      if (!rx_s) state_next = START;
      START:     if (half_done) state_next = rx_s ? IDLE : DATA;
      DATA:      if (full_done && (bit_cnt == 4'd7)) state_next = STOP;
      STOP:      if (full_done) state_next = rx_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Output / datapath-control decode
  always_comb begin
    start_load = 1'b0;
    phase_end  = 1'b0;
    sample_bit = 1'b0;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    unique case (state)
      IDLE:  start_load = !rx_s;
      START: phase_end  = half_done;
      DATA: begin
        phase_end  = full_done;
        sample_bit = full_done;
      end
      STOP: begin
        phase_end  = full_done;
        frame_good = full_done && rx_s;
        frame_bad  = full_done && !rx_s;
      end
      default: ;
    endcase
  end

  // Two-flop line synchronizer, idling high so reset never looks like a start bit.
  always_ff @(posedge sys_clk or posedge sys_rst_I) begin
    if (sys_rst_I) begin
      sync <= 2'b11;
    end else begin
      // NOTE: non-blocking assignments make both flops update from pre-edge values.
      sync <= {sync[0], uart_RECV_dataH};
    end
  end

  // Baud timing, bit assembly and output registers
  always_ff @(posedge sys_clk or posedge sys_rst_I) begin
    if (sys_rst_I) begin
      div         <= 16'd0;
      tick_cnt    <= 5'd0;
      bit_cnt     <= 4'd0;
      shift       <= 8'h00;
      recv_dataH  <= 8'h00;
      recv_readyH <= 1'b0;
      recv_errH   <= 1'b0;
    end else begin
      recv_readyH <= frame_good;
      recv_errH   <= frame_bad;

      if (start_load) begin
        div <= DIV_RELOAD;
      end else if (running) begin
        div <= tick ? DIV_RELOAD : div - 16'd1;
      end

      if (start_load || phase_end) begin
        tick_cnt <= 5'd0;
      end else if (tick) begin
        tick_cnt <= tick_cnt + 5'd1;
      end

      if (start_load) begin
        bit_cnt <= 4'd0;
      end else if (sample_bit) begin
        bit_cnt <= bit_cnt + 4'd1;
      end

      // LSB arrives first: inserting at the top and shifting right leaves it in bit 0.
      if (sample_bit) begin
        shift <= {rx_s, shift[7:1]};
      end

      if (frame_good) begin
        recv_dataH <= shift;
      end
    end
  end

endmodule

// File: tb/tb_u_recv.sv
// Self-checking bench for u_recv: directed scenarios plus randomized frames against an
// event-level reference model, and a default-rate instance fed by a behavioural transmitter.
module tb_u_recv;

  localparam int CD       = 4;
  localparam int SMP      = 4;
  localparam int BIT_LEN  = CD * SMP;
  localparam int STOP_LAT = 3 + (SMP / 2 + 9 * SMP) * CD;  // line fall -> strobe visible
  localparam int LB_CD    = 1302;
  localparam int LB_BIT   = LB_CD * 4;
  localparam int LB_LAT   = 3 + (4 / 2 + 9 * 4) * LB_CD;

  typedef struct {
    int         cyc;
    bit         err;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       line_a;
  logic       line_b;
  logic [7:0] data_a, data_b;
  logic       ready_a, ready_b;
  logic       err_a, err_b;
  logic       busy_a, busy_b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int busy_cycles = 0;
  ev_t got_q[$];
  ev_t exp_q[$];
  int lb_ready_n = 0;
  int lb_err_n = 0;
  int lb_cyc = 0;
  logic [7:0] lb_data = 8'h00;

  u_recv #(.CLOCK_DIVIDE(CD), .SAMPLES(SMP)) dut (
    .sys_clk        (clk),
    .sys_rst_I      (rst),
    .uart_RECV_dataH(line_a),
    .recv_dataH     (data_a),
    .recv_readyH    (ready_a),
    .recv_errH      (err_a),
    .recv_busyH     (busy_a)
  );

  u_recv lb_dut (
    .sys_clk        (clk),
    .sys_rst_I      (rst),
    .uart_RECV_dataH(line_b),
    .recv_dataH     (data_b),
    .recv_readyH    (ready_b),
    .recv_errH      (err_b),
    .recv_busyH     (busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Strobe monitor for the fast instance
  always @(negedge clk) begin
    if (ready_a || err_a) begin
      got_q.push_back('{cyc, err_a, data_a});
      check("strobe_exclusive", {31'd0, ready_a && err_a}, 32'd0);
    end
    if (busy_a) busy_cycles++;
  end

  always @(negedge clk) begin
    if (ready_b) begin
      lb_ready_n++;
      lb_data = data_b;
      lb_cyc  = cyc;
    end
    if (err_b) lb_err_n++;
  end

  task automatic drive(input int sel, input logic v, input int n);
    if (sel == 0) line_a = v;
    else line_b = v;
    repeat (n) @(negedge clk);
  endtask

  // Start bit, eight data bits LSB first, stop bit; line left at the stop level.
  task automatic send_frame(input int sel, input logic [7:0] b, input logic stop_bit,
                            input int bitlen);
    drive(sel, 1'b0, bitlen);
    for (int i = 0; i < 8; i++) drive(sel, b[i], bitlen);
    drive(sel, stop_bit, bitlen);
  endtask

  initial begin
    int c0;
    int c1;
    logic [7:0] exp_data;
    logic [7:0] b;
    logic stop_bit;
    int gap;

    rst = 1'b1;
    line_a = 1'b1;
    line_b = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", data_a, 8'h00);
    check("rst_ready", ready_a, 1'b0);
    check("rst_err", err_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_busy", busy_a, 1'b0);

    // Good frame 0xA5
    got_q.delete();
    busy_cycles = 0;
    c0 = cyc;
    send_frame(0, 8'hA5, 1'b1, BIT_LEN);
    drive(0, 1'b1, 20);
    check("a5_count", got_q.size(), 1);
    if (got_q.size() == 1) begin
      check("a5_err", got_q[0].err, 1'b0);
      check("a5_data", got_q[0].data, 8'hA5);
      check("a5_cycle", got_q[0].cyc, c0 + STOP_LAT);
    end
    check("a5_busy_len", busy_cycles, 152);
    check("a5_hold", data_a, 8'hA5);
    exp_data = 8'hA5;

    // Glitch rejection
    got_q.delete();
    busy_cycles = 0;
    drive(0, 1'b0, 6);
    drive(0, 1'b1, 30);
    check("glitch_count", got_q.size(), 0);
    check("glitch_busy_len", busy_cycles, 8);
    check("glitch_data", data_a, 8'hA5);

    // Framing error, line held low afterwards
    got_q.delete();
    c0 = cyc;
    send_frame(0, 8'h3C, 1'b0, BIT_LEN);
    drive(0, 1'b0, 40);
    check("ferr_count", got_q.size(), 1);
    if (got_q.size() == 1) begin
      check("ferr_err", got_q[0].err, 1'b1);
      check("ferr_cycle", got_q[0].cyc, c0 + STOP_LAT);
    end
    check("ferr_data", data_a, 8'hA5);
    check("ferr_wait_busy", busy_a, 1'b1);
    drive(0, 1'b1, 10);
    check("ferr_release", busy_a, 1'b0);
    check("ferr_single", got_q.size(), 1);

    // Back-to-back 0x00 then 0xFF, no gap
    got_q.delete();
    c0 = cyc;
    send_frame(0, 8'h00, 1'b1, BIT_LEN);
    send_frame(0, 8'hFF, 1'b1, BIT_LEN);
    drive(0, 1'b1, 20);
    check("b2b_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("b2b_data0", got_q[0].data, 8'h00);
      check("b2b_data1", got_q[1].data, 8'hFF);
      check("b2b_spacing", got_q[1].cyc - got_q[0].cyc, 160);
      check("b2b_cycle0", got_q[0].cyc, c0 + STOP_LAT);
    end
    exp_data = 8'hFF;

    // Randomized frames against the event model
    got_q.delete();
    exp_q.delete();
    for (int n = 0; n < 20; n++) begin
      b = 8'($urandom);
      stop_bit = ($urandom_range(0, 3) != 0);
      gap = stop_bit ? $urandom_range(0, 12) : $urandom_range(4, 12);
      c0 = cyc;
      if (stop_bit) exp_data = b;
      exp_q.push_back('{c0 + STOP_LAT, !stop_bit, exp_data});
      send_frame(0, b, stop_bit, BIT_LEN);
      if (gap > 0) drive(0, 1'b1, gap);
    end
    drive(0, 1'b1, 40);
    check("rand_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        check($sformatf("rand%0d_err", i), got_q[i].err, exp_q[i].err);
        check($sformatf("rand%0d_data", i), got_q[i].data, exp_q[i].data);
        check($sformatf("rand%0d_cycle", i), got_q[i].cyc, exp_q[i].cyc);
      end
    end

    // Reset asserted in the 4th data bit of 0x81
    got_q.delete();
    drive(0, 1'b0, BIT_LEN);
    drive(0, 1'b1, BIT_LEN);
    drive(0, 1'b0, BIT_LEN);
    drive(0, 1'b0, BIT_LEN);
    drive(0, 1'b0, BIT_LEN / 2);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_data", data_a, 8'h00);
    check("mid_rst_busy", busy_a, 1'b0);
    check("mid_rst_ready", ready_a, 1'b0);
    check("mid_rst_err", err_a, 1'b0);
    line_a = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_rst_nostrobe", got_q.size(), 0);
    c0 = cyc;
    send_frame(0, 8'h7E, 1'b1, BIT_LEN);
    drive(0, 1'b1, 20);
    check("post_rst_count", got_q.size(), 1);
    if (got_q.size() == 1) begin
      check("post_rst_data", got_q[0].data, 8'h7E);
      check("post_rst_cycle", got_q[0].cyc, c0 + STOP_LAT);
    end

    // Loopback with a behavioural transmitter at default rate
    lb_ready_n = 0;
    lb_err_n = 0;
    c1 = cyc;
    send_frame(1, 8'h55, 1'b1, LB_BIT);
    drive(1, 1'b1, 100);
    check("lb_ready_count", lb_ready_n, 1);
    check("lb_err_count", lb_err_n, 0);
    check("lb_data", lb_data, 8'h55);
    check("lb_cycle", lb_cyc, c1 + LB_LAT);
    check("lb_busy", busy_b, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
